// File: rtl/gdemux16_reg.sv
// gdemux16_reg: 1-to-2 ready/valid demux with a one-entry registered buffer and handshake counter per port
module gdemux16_reg #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);
  logic [WIDTH-1:0] r_data0, r_data1;
  logic             r_valid0, r_valid1;
  logic [CNTW-1:0]  r_cnt0, r_cnt1;
  logic             w_ready, w_load0, w_load1, w_drain0, w_drain1;

  // A port can take a word when empty or when it is draining this same cycle
  always_comb begin
    w_ready  = rst_n & (in_sel ? (~r_valid1 | out1_ready) : (~r_valid0 | out0_ready));
    w_load0  = in_valid & w_ready & ~in_sel;
    w_load1  = in_valid & w_ready & in_sel;
    w_drain0 = r_valid0 & out0_ready;
    w_drain1 = r_valid1 & out1_ready;
  end

  // Port 0 buffer: refill wins over drain so a simultaneous swap leaves no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data0  <= '0;
      r_valid0 <= 1'b0;
      r_cnt0   <= '0;
    end else begin
      if (w_load0) r_data0 <= in_data;
      r_valid0 <= w_load0 | (r_valid0 & ~w_drain0);
      if (w_drain0) r_cnt0 <= r_cnt0 + 1'b1;
    end
  end

  // Port 1 buffer: same behaviour as port 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data1  <= '0;
      r_valid1 <= 1'b0;
      r_cnt1   <= '0;
    end else begin
      if (w_load1) r_data1 <= in_data;
      r_valid1 <= w_load1 | (r_valid1 & ~w_drain1);
      if (w_drain1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign in_ready   = w_ready;
  assign out0_data  = r_data0;
  assign out0_valid = r_valid0;
  assign out1_data  = r_data1;
  assign out1_valid = r_valid1;
  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;
endmodule

// File: tb/tb_gdemux16_reg.sv
// tb_gdemux16_reg: directed bench with a queue-based reference model checked every cycle
module tb_gdemux16_reg;
  localparam int W = 16;
  localparam int C = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_sel = 1'b0, in_valid = 1'b0, out0_ready = 1'b0, out1_ready = 1'b0;
  logic         in_ready, out0_valid, out1_valid;
  logic [W-1:0] out0_data, out1_data;
  logic [C-1:0] cnt0, cnt1;

  gdemux16_reg #(.WIDTH(W), .CNTW(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [W-1:0] q0[$], q1[$];
  logic [W-1:0] md0 = '0, md1 = '0;
  logic [C-1:0] mc0 = '0, mc1 = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge rst_n) begin
    q0.delete();
    q1.delete();
    md0 = '0;
    md1 = '0;
    mc0 = '0;
    mc1 = '0;
  end

  always @(negedge clk) begin
    logic er, e0, e1;
    e0 = q0.size() != 0;
    e1 = q1.size() != 0;
    er = rst_n & (in_sel ? (!e1 | out1_ready) : (!e0 | out0_ready));
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out0_valid", 32'(out0_valid), 32'(e0));
    chk("out1_valid", 32'(out1_valid), 32'(e1));
    if (e0) chk("out0_data", 32'(out0_data), 32'(q0[0]));
    else chk("out0_data", 32'(out0_data), 32'(md0));
    if (e1) chk("out1_data", 32'(out1_data), 32'(q1[0]));
    else chk("out1_data", 32'(out1_data), 32'(md1));
    chk("cnt0", 32'(cnt0), 32'(mc0));
    chk("cnt1", 32'(cnt1), 32'(mc1));
    if (rst_n) begin
      if (e0 && out0_ready) begin
        void'(q0.pop_front());
        mc0++;
      end
      if (e1 && out1_ready) begin
        void'(q1.pop_front());
        mc1++;
      end
      if (in_valid && er) begin
        if (in_sel) begin
          q1.push_back(in_data);
          md1 = in_data;
        end else begin
          q0.push_back(in_data);
          md0 = in_data;
        end
      end
      if (q0.size() > 1 || q1.size() > 1) chk("model depth", 32'(q0.size() + q1.size()), 32'(2));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    cyc(2);
    chk("rst in_ready", 32'(in_ready), 32'(0));
    rst_n = 1'b1;
    #1 chk("post-rst in_ready", 32'(in_ready), 32'(1));
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h3524;
    cyc(1);
    in_valid = 1'b0;
    #1 chk("s1 out0_valid", 32'(out0_valid), 32'(1));
    chk("s1 out0_data", 32'(out0_data), 32'h3524);
    chk("s1 out1_valid", 32'(out1_valid), 32'(0));
    in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h5E81;
    cyc(1);
    in_data = 16'hD609;
    #1 chk("s2 blocked in_ready", 32'(in_ready), 32'(0));
    cyc(1);
    #1 chk("s2 held out1_data", 32'(out1_data), 32'h5E81);
    out1_ready = 1'b1;
    #1 chk("s2 swap in_ready", 32'(in_ready), 32'(1));
    chk("s2 cnt1 before", 32'(cnt1), 32'(0));
    cyc(1);
    in_valid = 1'b0; out1_ready = 1'b0;
    #1 chk("s2 out1_data", 32'(out1_data), 32'hD609);
    chk("s2 out1_valid", 32'(out1_valid), 32'(1));
    chk("s2 cnt1", 32'(cnt1), 32'(1));
    out0_ready = 1'b1;
    cyc(1);
    out0_ready = 1'b0;
    #1 chk("s3 out0 drained", 32'(out0_valid), 32'(0));
    chk("s3 cnt0", 32'(cnt0), 32'(1));
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h5663;
    #1 chk("s3 in_ready", 32'(in_ready), 32'(1));
    cyc(1);
    in_valid = 1'b0;
    #1 chk("s3 out0_data", 32'(out0_data), 32'h5663);
    chk("s3 out1_data", 32'(out1_data), 32'hD609);
    chk("s3 cnt1", 32'(cnt1), 32'(1));
    for (int i = 0; i < 10; i++) begin
      in_sel = 1'($urandom);
      in_data = 16'($urandom);
      cyc(1);
    end
    #1 chk("s4 out0_data", 32'(out0_data), 32'h5663);
    chk("s4 out1_data", 32'(out1_data), 32'hD609);
    chk("s4 cnts", 32'({cnt1, cnt0}), 32'h0101);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("s5 valids", 32'({out1_valid, out0_valid}), 32'(0));
    chk("s5 data", 32'({out1_data, out0_data}), 32'(0));
    chk("s5 cnts", 32'({cnt1, cnt0}), 32'(0));
    chk("s5 in_ready", 32'(in_ready), 32'(0));
    cyc(1);
    rst_n = 1'b1;
    out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_data = 16'(i * 37 + 5);
      cyc(1);
    end
    in_valid = 1'b0;
    cyc(1);
    out0_ready = 1'b0;
    #1 chk("s6 cnt0 wrap", 32'(cnt0), 32'(0));
    chk("s6 out0_valid", 32'(out0_valid), 32'(0));
    chk("s6 model drained", 32'(q0.size()), 32'(0));
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gdemux16_reg.md
GDEMUX16_REG -- requirements
Module: gdemux16_reg

Interface
REQ-001 Parameter WIDTH, default 16: data width of the input and of each output port.
REQ-002 Parameter CNTW, default 8: width of each per-port transfer counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_data  input  WIDTH  word to be routed.
REQ-007 in_sel  input  1  destination select: 0 routes to port 0, 1 routes to port 1.
REQ-008 in_valid  input  1  in_data and in_sel are valid this cycle.
REQ-009 in_ready  output  1  block accepts the input word this cycle.
REQ-010 out0_data, out1_data  output  WIDTH  registered data, one per port.
REQ-011 out0_valid, out1_valid  output  1  port holds a valid word.
REQ-012 out0_ready, out1_ready  input  1  downstream consumer accepts the port word.
REQ-013 cnt0, cnt1  output  CNTW  count of completed output handshakes per port.

Function
REQ-014 Each port SHALL hold a one-entry buffer made of a data register and a valid flag; outN_data and outN_valid SHALL be driven directly from these registers.
REQ-015 in_ready SHALL be computed combinationally as (~outS_valid | outS_ready), where S = in_sel, and SHALL be forced to 0 while rst_n is low.
REQ-016 An input handshake is in_valid & in_ready; on this handshake the selected port SHALL capture in_data and set its valid flag at the next clock edge (1-cycle latency).
REQ-017 An output handshake is outN_valid & outN_ready; on this handshake outN_valid SHALL clear at the next edge, unless the same port is refilled in that cycle.
REQ-018 Simultaneous drain and refill of the same port SHALL leave valid at 1 with the new data, with no bubble and no loss.
REQ-019 The unselected port SHALL keep its data, valid flag and counter unchanged by the input handshake; it may still complete its own output handshake in the same cycle.
REQ-020 While outN_valid=1 and outN_ready=0, outN_data SHALL stay stable.
REQ-021 While in_valid=0, no port SHALL be written, whatever in_data and in_sel are.
REQ-022 in_data and in_sel SHALL be ignored when in_ready=0; the upstream holds the word, and no word is dropped or duplicated.
REQ-023 cntN SHALL increment by 1 on each port-N output handshake.
REQ-024 cntN SHALL wrap from 2^CNTW-1 to 0 without saturating.
REQ-025 No outN_ready input SHALL combinationally affect any outN_valid or outN_data output.

Reset
REQ-026 On rst_n low, the block SHALL asynchronously clear out0_valid, out1_valid, out0_data, out1_data, cnt0 and cnt1 to 0 and drive in_ready to 0.
REQ-027 A reset asserted mid-operation SHALL discard any buffered words.
REQ-028 After rst_n is released, the first rising edge SHALL be able to accept an input word; in_ready=1 at that point because both valid flags are 0.

Verification
REQ-029 Scenario: after reset, in_valid=1, in_sel=0, in_data=16'h3524 for one cycle -> next cycle out0_valid=1, out0_data=16'h3524, out1_valid=0.
REQ-030 Scenario: port 1 full (data 16'h5E81) with out1_ready=0; drive in_sel=1 with 16'hD609 -> in_ready=0, out1_data stays 16'h5E81; then set out1_ready=1 -> 16'hD609 loaded the same edge 16'h5E81 drains, and cnt1 increments by 1.
REQ-031 Scenario: port 1 blocked and port 0 empty; drive in_sel=0 with 16'h5663 -> in_ready=1, out0_data=16'h5663 next cycle, port 1 unchanged.
REQ-032 Scenario: hold out0_ready=1 and stream 256 words to port 0 -> cnt0 returns to 0 (CNTW=8), and every word appears exactly once in order.
REQ-033 Scenario: assert rst_n=0 asynchronously, between edges, while both ports are valid -> all outputs go to 0 immediately, without waiting for a clock edge.
REQ-034 Scenario: hold in_valid=0 while toggling in_sel and in_data randomly for 10 cycles -> no valid flag or counter changes.
